npc_mem_responder: RTL

Memory-side responder for the npc core. It serves instruction fetches over the core's valid/ready instruction port with a programmable latency, and services the core's data port: combinational read plus byte/half/word writes. It sits beside the core in the simulation top and replaces the testbench-driven instruction and data stimulus. With trap detection compiled in, it also flags `ebreak` delivery.

---
 rtl/npc_mem_responder_if.sv | 28 ++
 rtl/npc_mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/npc_mem_responder_if.sv
// Bus bundle between the npc core and its memory responder: instruction
// fetch handshake, data read/write port and the sticky status flags.
interface npc_mem_responder_if;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        inst_valid;
  logic [31:0] inst_bits;
  logic        inst_ready;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [2:0]  mem_wop;
  logic [31:0] mem_wdata;
  logic        mem_err;
  logic        trap;

  // Core side.
  modport master (
    output fetch_en, fetch_addr, inst_ready, mem_raddr, mem_wen, mem_wop, mem_wdata,
    input  inst_valid, inst_bits, mem_rdata, mem_err, trap
  );

  // Memory responder side.
  modport slave (
    input  fetch_en, fetch_addr, inst_ready, mem_raddr, mem_wen, mem_wop, mem_wdata,
    output inst_valid, inst_bits, mem_rdata, mem_err, trap
  );
endinterface

// File: rtl/npc_mem_responder.sv
// Memory responder for the npc core: latency-programmable instruction fetch plus a
// combinational-read, byte/half/word-write data port. Define NPC_MEM_TRAP_EN for ebreak trapping.
module npc_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input logic                 clock,
  input logic                 reset,
  npc_mem_responder_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) << 2;
  localparam int unsigned CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [31:0]   bits_q, bits_d;
  logic          err_q, err_d;
  logic          trap_block;

  // Data port decode, shared by the combinational read and the write path.
  logic [31:0]   r_off;
  logic          r_in_range;
  logic [AW-1:0] r_idx;

  assign r_off      = bus.mem_raddr - BASE_ADDR;
  assign r_in_range = (r_off < SPAN);
  assign r_idx      = r_off[AW+1:2];

  assign bus.mem_rdata = r_in_range ? mem[r_idx] : 32'h0;

  logic [3:0]  wr_be;
  logic [31:0] wr_word;
  logic        wr_err;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = 32'h0;
    wr_err  = 1'b0;
    if (bus.mem_wen) begin
      case (bus.mem_wop)
        3'b000: begin
          if (!r_in_range) begin
            wr_err = 1'b1;
          end else begin
            wr_be   = 4'b0001 << bus.mem_raddr[1:0];
            wr_word = {4{bus.mem_wdata[7:0]}};
          end
        end
        3'b001: begin
          if (!r_in_range || bus.mem_raddr[0]) begin
            wr_err = 1'b1;
          end else begin
            wr_be   = bus.mem_raddr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{bus.mem_wdata[15:0]}};
          end
        end
        3'b010: begin
          if (!r_in_range || (bus.mem_raddr[1:0] != 2'b00)) begin
            wr_err = 1'b1;
          end else begin
            wr_be   = 4'b1111;
            wr_word = bus.mem_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Store has no reset; contents survive reset and are preloaded via the write port.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem[r_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
  end

  // Fetch address decode on the latched PC.
  logic [31:0]   f_off;
  logic          f_ok;
  logic [AW-1:0] f_idx;
  logic [31:0]   f_word;

  assign f_off  = addr_q - BASE_ADDR;
  assign f_ok   = (f_off < SPAN) && (addr_q[1:0] == 2'b00);
  assign f_idx  = f_off[AW+1:2];
  assign f_word = f_ok ? mem[f_idx] : NOP;

`ifdef NPC_MEM_TRAP_EN
  logic trap_q, trap_d;
  assign trap_block = trap_q;
  assign bus.trap   = trap_q;
`else
  assign trap_block = 1'b0;
  assign bus.trap   = 1'b0;
`endif

  logic fetch_err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    bits_d    = bits_q;
    fetch_err = 1'b0;
`ifdef NPC_MEM_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch_en && !trap_block) begin
          addr_d  = bus.fetch_addr;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Capture reads the store before any same-edge write lands.
        if (cnt_q == '0) begin
          bits_d    = f_word;
          valid_d   = 1'b1;
          fetch_err = !f_ok;
          state_d   = ST_VALID;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_VALID: begin
        if (bus.inst_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
`ifdef NPC_MEM_TRAP_EN
          if (bits_q == EBREAK) begin
            trap_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_q | wr_err | fetch_err;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      valid_q <= 1'b0;
      bits_q  <= 32'h0;
      err_q   <= 1'b0;
`ifdef NPC_MEM_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
`ifdef NPC_MEM_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign bus.inst_valid = valid_q;
  assign bus.inst_bits  = bits_q;
  assign bus.mem_err    = err_q;

endmodule
